normalize_round: RTL and testbench

NORMALIZE_ROUND -- requirements
Module: normalize_round

---
 rtl/normalize_round.sv | 127 ++++++++++++
 tb/tb_normalize_round.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/normalize_round.sv
// Normalize-and-round stage for single-precision addition. Takes an aligned
// 28-bit sum (carry, hidden, fraction, guard, round, sticky), normalizes it one
// bit per cycle, rounds to nearest-even and packs an IEEE-754 result.
module normalize_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_inexact
);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  state_e      r_state, w_state;
  logic        r_sign, w_sign;
  logic [8:0]  r_exp, w_exp;
  logic [27:0] r_mant, w_mant;
  logic [31:0] r_result, w_result;
  logic        r_ovf, w_ovf;
  logic        r_inexact, w_inexact;

  // Rounding datapath, only consumed in StRound.
  logic        w_inc;
  logic [24:0] w_sum;
  logic [23:0] w_field;
  logic [8:0]  w_exp_rnd;

  // Round-to-nearest-even on the 24-bit significand [26:3].
  assign w_inc     = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
  assign w_sum     = {1'b0, r_mant[26:3]} + 25'(w_inc);
  assign w_field   = w_sum[24] ? w_sum[24:1] : w_sum[23:0];
  assign w_exp_rnd = r_exp + 9'(w_sum[24]);

  assign in_ready     = (r_state == StIdle);
  assign out_valid    = (r_state == StDone);
  assign out_result   = r_result;
  assign out_overflow = r_ovf;
  assign out_inexact  = r_inexact;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_sign    <= 1'b0;
      r_exp     <= 9'd0;
      r_mant    <= 28'd0;
      r_result  <= 32'd0;
      r_ovf     <= 1'b0;
      r_inexact <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_sign    <= w_sign;
      r_exp     <= w_exp;
      r_mant    <= w_mant;
      r_result  <= w_result;
      r_ovf     <= w_ovf;
      r_inexact <= w_inexact;
    end
  end

  // Next-state and datapath update for each FSM state.
  always_comb begin
    w_state   = r_state;
    w_sign    = r_sign;
    w_exp     = r_exp;
    w_mant    = r_mant;
    w_result  = r_result;
    w_ovf     = r_ovf;
    w_inexact = r_inexact;
    case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_sign  = in_sign;
          // A zero exponent behaves as 1 so denormals share the normal path.
          w_exp   = (in_exp == 8'd0) ? 9'd1 : {1'b0, in_exp};
          w_mant  = in_mant;
          w_state = StNorm;
        end
      end
      StNorm: begin
        if (r_mant == 28'd0) begin
          w_result  = 32'd0;
          w_ovf     = 1'b0;
          w_inexact = 1'b0;
          w_state   = StDone;
        end else if (r_mant[27]) begin
          // Carry-out: shift right, folding the lost bit into sticky.
          w_mant  = {1'b0, r_mant[27:2], r_mant[1] | r_mant[0]};
          w_exp   = r_exp + 9'd1;
          w_state = StRound;
        end else if (r_mant[26] || (r_exp == 9'd1)) begin
          w_state = StRound;
        end else begin
          // One left shift per cycle; sticky stays in place.
          w_mant = {r_mant[26:1], 1'b0, r_mant[0]};
          w_exp  = r_exp - 9'd1;
        end
      end
      StRound: begin
        w_inexact = |r_mant[2:0];
        if (w_exp_rnd >= 9'd255) begin
          w_result = {r_sign, 8'hFF, 23'd0};
          w_ovf    = 1'b1;
        end else begin
          w_ovf = 1'b0;
          // Without the hidden bit the exponent is necessarily 1: denormal.
          w_result = {r_sign, w_field[23] ? w_exp_rnd[7:0] : 8'h00, w_field[22:0]};
        end
        w_state = StDone;
      end
      StDone: begin
        if (out_ready) begin
          w_state = StIdle;
        end
      end
      default: w_state = StIdle;
    endcase
  end

endmodule

// File: tb/tb_normalize_round.sv
// Scoreboard bench for normalize_round: a driver pushes expected results from a
// behavioural model, a monitor pops and compares on out_valid with backpressure.
module tb_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_inexact;

  normalize_round dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_inexact  (out_inexact)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        inex;
    int          lat;
    int unsigned acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: find the normalization shift from the leading one, then round
  // by comparing the 3 low bits against the halfway point.
  function automatic exp_t model(input bit s, input bit [7:0] ei, input bit [27:0] mi);
    exp_t r;
    int e, n, lz;
    bit [27:0] m;
    bit [24:0] q;
    bit [2:0] rem;
    bit up;
    r.acc = 0;
    n = 0;
    e = (ei == 8'd0) ? 1 : int'(ei);
    m = mi;
    if (m == 28'd0) begin
      r.res = 32'd0; r.ovf = 1'b0; r.inex = 1'b0; r.lat = 2;
      return r;
    end
    if (m[27]) begin
      m = (m >> 1) | (m & 28'd1);
      e++;
    end else begin
      lz = 0;
      while (lz < 26 && !m[26-lz]) lz++;
      if (lz == 26) lz = 1000;
      n = (lz < e - 1) ? lz : e - 1;
      m = ((m & 28'hFFFFFFE) << n) | (m & 28'd1);
      e -= n;
    end
    q   = {1'b0, m[26:3]};
    rem = m[2:0];
    up  = (rem > 3'd4) || (rem == 3'd4 && q[0]);
    r.inex = (rem != 3'd0);
    q = q + 25'(up);
    if (q[24]) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) begin
      r.res = {s, 8'hFF, 23'd0};
      r.ovf = 1'b1;
    end else begin
      r.ovf = 1'b0;
      r.res = {s, q[23] ? 8'(e) : 8'h00, q[22:0]};
    end
    r.lat = n + 3;
    return r;
  endfunction

  // Drive one operand; optionally record its expectation in the scoreboard.
  task automatic issue(input bit s, input bit [7:0] ei, input bit [27:0] mi,
                       input exp_t e, input bit push);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = ei;
    in_mant  = mi;
    @(posedge clk);
    #1;
    e.acc = cyc;
    if (push) sb.push_back(e);
    // Junk while busy must be ignored.
    in_sign = 1'($urandom);
    in_exp  = 8'($urandom_range(0, 254));
    in_mant = 28'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_dir(input bit s, input bit [7:0] ei, input bit [27:0] mi,
                         input logic [31:0] res, input bit ovf, input bit inex, input int lat);
    exp_t e;
    e.res = res; e.ovf = ovf; e.inex = inex; e.lat = lat; e.acc = 0;
    issue(s, ei, mi, e, 1'b1);
  endtask

  // Monitor: compare on out_valid, apply random backpressure, check stability.
  initial begin
    exp_t e;
    int hold;
    logic [31:0] snap;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", out_result, e.res);
          check("overflow", {31'd0, out_overflow}, {31'd0, e.ovf});
          check("inexact", {31'd0, out_inexact}, {31'd0, e.inex});
          check("latency", cyc - e.acc + 1, e.lat);
          snap = out_result;
          hold = (n_done == 0) ? 5 : $urandom_range(0, 5);
          repeat (hold) begin
            @(negedge clk);
            check("hold_result", out_result, snap);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
          end
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
          check("valid_drop", {31'd0, out_valid}, 32'd0);
          n_done++;
        end
      end
    end
  end

  initial begin
    exp_t e;
    bit s;
    bit [7:0] ei;
    bit [27:0] mi;
    int t;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_exp   = 8'd0;
    in_mant  = 28'd0;
    repeat (2) @(negedge clk);
    // Operand offered during reset must not be taken.
    in_valid = 1'b1;
    in_exp   = 8'd127;
    in_mant  = 28'h8000000;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_overflow", {31'd0, out_overflow}, 32'd0);
    check("rst_inexact", {31'd0, out_inexact}, 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {31'd0, in_ready}, 32'd1);

    // Directed vectors.
    run_dir(1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 3);
    run_dir(1'b0, 8'd127, 28'h0000008, 32'h34000000, 1'b0, 1'b0, 26);
    run_dir(1'b0, 8'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b1, 3);
    run_dir(1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b1, 3);
    run_dir(1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b1, 3);
    run_dir(1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 3);
    run_dir(1'b0, 8'd1,   28'h2000000, 32'h00400000, 1'b0, 1'b0, 3);
    run_dir(1'b1, 8'd127, 28'h0000000, 32'h00000000, 1'b0, 1'b0, 2);

    // Reset pulse while normalizing: no output, then a clean operation.
    e = model(1'b0, 8'd127, 28'h0000008);
    issue(1'b0, 8'd127, 28'h0000008, e, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    run_dir(1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 3);

    // Randomized operands against the model.
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       ei = 8'($urandom_range(0, 2));
        1:       ei = 8'($urandom_range(3, 30));
        2:       ei = 8'($urandom_range(250, 254));
        default: ei = 8'($urandom_range(0, 254));
      endcase
      mi = 28'($urandom) >> $urandom_range(0, 27);
      if ($urandom_range(0, 4) == 0) mi[27] = 1'b1;
      e = model(s, ei, mi);
      issue(s, ei, mi, e, 1'b1);
    end

    t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
